// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the timing generator, renderer and sprite logic.
// Also holds a small width helper used to size the raster counters.
package vga_timing_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;

    // Centre of the visible window in raster coordinates: (464,275).
    localparam int SCREEN_XCENTER = H_START + H_ACTIVE / 2;
    localparam int SCREEN_YCENTER = V_START + V_ACTIVE / 2;

    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD counter advancing on inc; wrap flags the increment that returns it to zero.
// Used for the pixel divider and the horizontal and vertical raster counters.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int MOD = 2,
    localparam int W  = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && (count == LAST);

    // NOTE: state registers use non-blocking assignments so every chained counter sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, sync/blanking and frame strobes.
// Every output is registered from next-state counter values, so all outputs stay cycle-aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pixel_tick,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DW    = cnt_width(CLK_DIV);
    localparam int HW    = cnt_width(H_TOT);
    localparam int VW    = cnt_width(V_TOT);

    // One spare bit so the window end compares correctly even when it equals a power of two.
    localparam logic [HW:0] H_SYNC_END  = (HW + 1)'(H_SYNC);
    localparam logic [HW:0] H_ACT_BEGIN = (HW + 1)'(H_SYNC + H_BP);
    localparam logic [HW:0] H_ACT_END   = (HW + 1)'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW:0] V_SYNC_END  = (VW + 1)'(V_SYNC);
    localparam logic [VW:0] V_ACT_BEGIN = (VW + 1)'(V_SYNC + V_BP);
    localparam logic [VW:0] V_ACT_END   = (VW + 1)'(V_SYNC + V_BP + V_ACTIVE);

    generate
        if (CLK_DIV < 1 || H_TOT > 1024 || V_TOT > 1024) begin : g_bad_params
            $error("vga_timing_gen: CLK_DIV must be >= 1 and raster totals must be <= 1024");
        end
    endgenerate

    logic [DW-1:0] w_div_count;
    logic          w_div_wrap;
    logic [HW-1:0] w_h_count;
    logic          w_h_wrap;
    logic [VW-1:0] w_v_count;
    logic          w_v_wrap;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    logic [HW:0]   w_h_ext;
    logic [VW:0]   w_v_ext;
    logic          w_unused;

    mod_counter #(.MOD(CLK_DIV)) u_div (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .count (w_div_count),
        .wrap  (w_div_wrap)
    );

    mod_counter #(.MOD(H_TOT)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_div_wrap),
        .count (w_h_count),
        .wrap  (w_h_wrap)
    );

    mod_counter #(.MOD(V_TOT)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_h_wrap),
        .count (w_v_count),
        .wrap  (w_v_wrap)
    );

    assign w_unused = ^w_div_count;

    // Values the h/v counters will hold after this edge.
    assign w_h_next = w_div_wrap ? (w_h_wrap ? '0 : w_h_count + 1'b1) : w_h_count;
    assign w_v_next = w_h_wrap   ? (w_v_wrap ? '0 : w_v_count + 1'b1) : w_v_count;
    assign w_h_ext  = {1'b0, w_h_next};
    assign w_v_ext  = {1'b0, w_v_next};

    logic        r_pixel_tick;
    logic        r_frame_start;
    logic        r_bright;
    logic        r_hsync;
    logic        r_vsync;
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_tick  <= 1'b0;
            r_frame_start <= 1'b0;
            r_bright      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_pixel_tick  <= w_div_wrap;
            r_frame_start <= w_v_wrap;
            r_bright      <= (w_h_ext >= H_ACT_BEGIN) && (w_h_ext < H_ACT_END) &&
                             (w_v_ext >= V_ACT_BEGIN) && (w_v_ext < V_ACT_END);
            r_hsync       <= !(w_h_ext < H_SYNC_END);
            r_vsync       <= !(w_v_ext < V_SYNC_END);
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign pixel_tick  = r_pixel_tick;
    assign frame_start = r_frame_start;
    assign bright      = r_bright;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign frame_cnt   = r_frame_cnt;
    assign hCount      = 10'(w_h_count);
    assign vCount      = 10'(w_v_count);

endmodule
